// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked EX-stage ALU with an iterative multiply.
// Ports: clk, rst_n; in_valid/in_ready + op_a, op_b, alucontrol in;
//        out_valid/out_ready + result, zero out; busy while multiplying.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHAMT_W-1:0] cnt;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   acc_sum;
  logic               accept;
  logic               start_mul;
  logic               mul_last;

  assign shamt     = op_b[SHAMT_W-1:0];
  assign in_ready  = (state == IDLE) ||
                     ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign start_mul = accept && (alucontrol == 4'b1011);
  assign mul_last  = (cnt == '0);
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL);

  // One shift-add step; the last step's sum is the product.
  assign acc_sum = mplier[0] ? acc + mcand : acc;

  always_comb begin
    alu_res = '1;
    unique case (alucontrol)
      4'b0000: alu_res = op_a + op_b;
      4'b0001: alu_res = op_a - op_b;
      4'b0010: alu_res = op_a ^ op_b;
      4'b0011: alu_res = op_a | op_b;
      4'b0100: alu_res = op_a & op_b;
      4'b0101: alu_res = ~op_a;
      4'b0110: alu_res = op_a << shamt;
      4'b0111: alu_res = op_a >> shamt;
      4'b1000: alu_res = {{(WIDTH-1){1'b0}},
                          (op_a < op_b)};
      4'b1001: alu_res = $signed(op_a) >>> shamt;
      4'b1010: alu_res = {{(WIDTH-1){1'b0}},
                          ($signed(op_a) < $signed(op_b))};
      default: alu_res = '1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nx = start_mul ? MUL : DONE;
        end else if ((state == DONE) && out_ready) begin
          state_nx = IDLE;
        end
      end
      MUL: begin
        if (mul_last) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (start_mul) begin
        acc    <= '0;
        mcand  <= op_a;
        mplier <= op_b;
        cnt    <= SHAMT_W'(WIDTH - 1);
      end else begin
        result <= alu_res;
        zero   <= (alu_res == '0);
      end
    end else if (state == MUL) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - SHAMT_W'(1);
      if (mul_last) begin
        result <= acc_sum;
        zero   <= (acc_sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against
// an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   alucontrol;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .alucontrol (alucontrol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .busy       (busy)
  );

  function automatic logic [W-1:0] model(
    input logic [3:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    int unsigned s;
    logic [W-1:0] r;
    s = int'(b[4:0]);
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a ^ b;
      4'd3:  r = a | b;
      4'd4:  r = a & b;
      4'd5:  r = ~a;
      4'd6:  r = a << s;
      4'd7:  r = a >> s;
      4'd8:  r = (a < b) ? 1 : 0;
      4'd9: begin
        r = a >> s;
        if (a[W-1]) r = r | ~(32'hFFFF_FFFF >> s);
      end
      4'd10: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 1 : 0;
      4'd11: r = a * b;
      default: r = 32'hFFFF_FFFF;
    endcase
    return r;
  endfunction

  task automatic chk(
    input string tag,
    input logic [W-1:0] obs,
    input logic [W-1:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left on a negedge with out_ready high.
  task automatic do_op(
    input string tag,
    input logic [3:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] e;
    int n;
    logic ir_bad;
    e = model(op, a, b);
    alucontrol = op;
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    alucontrol = 4'($urandom);
    if (op == 4'd11) begin
      n = 0;
      ir_bad = 1'b0;
      while (busy && n < 100) begin
        if (in_ready) ir_bad = 1'b1;
        n++;
        @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, n, 32);
      chk({tag, "_ready_in_mul"}, ir_bad, 0);
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_result"}, result, e);
    chk({tag, "_zero"}, zero, (e == 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic flag;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op_a = '0;
    op_b = '0;
    alucontrol = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back add then sub.
    alucontrol = 4'd0;
    op_a = 32'h7FFF_FFFF;
    op_b = 32'h1;
    in_valid = 1'b1;
    #1;
    chk("b2b_pre_valid", out_valid, 0);
    chk("b2b_ready0", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("add_valid", out_valid, 1);
    chk("add_result", result, 32'h8000_0000);
    chk("add_zero", zero, 0);
    alucontrol = 4'd1;
    op_a = 32'd5;
    op_b = 32'd5;
    #1;
    chk("b2b_ready1", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("sub_valid", out_valid, 1);
    chk("sub_result", result, 0);
    chk("sub_zero", zero, 1);
    @(negedge clk);

    // Backpressure.
    out_ready = 1'b0;
    alucontrol = 4'd1;
    op_a = 32'h10;
    op_b = 32'h10;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    alucontrol = 4'd0;
    op_a = 32'd1;
    op_b = 32'd2;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 0);
      chk("bp_zero", zero, 1);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_result", result, 3);

    // Shifts, compares, reserved opcode.
    do_op("sra", 4'd9, 32'h8000_0000, 32'd4);
    chk("sra_exact", result, 32'hF800_0000);
    do_op("srl", 4'd7, 32'h8000_0000, 32'd4);
    chk("srl_exact", result, 32'h0800_0000);
    do_op("sll", 4'd6, 32'h8000_0000, 32'd4);
    chk("sll_zero_exact", zero, 1);
    do_op("sll_sh0", 4'd6, 32'h1234_5678, 32'hFFFF_FFE0);
    chk("sh0_exact", result, 32'h1234_5678);
    do_op("slt", 4'd10, 32'hFFFF_FFFF, 32'd1);
    chk("slt_exact", result, 1);
    do_op("sltu", 4'd8, 32'hFFFF_FFFF, 32'd1);
    chk("sltu_exact", result, 0);
    do_op("op15", 4'd15, 32'hFFFF_FFFF, 32'd1);
    chk("op15_exact", result, 32'hFFFF_FFFF);

    // Multiplies.
    do_op("mul3", 4'd11, 32'hFFFF_FFFF, 32'd3);
    chk("mul3_exact", result, 32'hFFFF_FFFD);
    do_op("mul_ovf", 4'd11, 32'h0001_0000, 32'h0001_0000);
    chk("mul_ovf_zero", zero, 1);

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      do_op("rnd", 4'($urandom_range(0, 15)),
            $urandom, $urandom);
    end

    // Reset in the middle of a multiply.
    do_op("pre_rst", 4'd0, 32'd7, 32'd8);
    alucontrol = 4'd11;
    op_a = 32'hDEAD_BEEF;
    op_b = 32'h1234_5678;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_mul_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_zero", zero, 0);
    chk("abort_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) flag = 1'b1;
    end
    chk("abort_no_result", flag, 0);
    do_op("post_rst_add", 4'd0, 32'd2, 32'd3);
    chk("post_rst_exact", result, 5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
